// File: rtl/hazard_forwarding_unit.sv
// Hazard detection and forwarding-select generation from a shadow EX/MEM/WB pipeline of dest/write/load.
// Outputs are combinational from shadow state plus the ID instruction; load-use inserts exactly one bubble.
module hazard_forwarding_unit #(
    parameter int NUM_STAGES_TRACKED = 3,
    parameter int STALL_CNT_W        = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic                   id_uses_rs,
    input  logic                   id_uses_rt,
    input  logic [4:0]             id_dest_reg,
    input  logic                   id_rf_enable,
    input  logic                   id_load_instr,
    output logic [1:0]             fwd_sel_a,
    output logic [1:0]             fwd_sel_b,
    output logic                   control_mux,
    output logic                   pc_load_enable,
    output logic                   if_id_load_enable,
    output logic [STALL_CNT_W-1:0] stall_count
);

    generate
        if (NUM_STAGES_TRACKED != 3) begin : g_bad_stage_count
            $error("hazard_forwarding_unit supports exactly 3 tracked stages");
        end
    endgenerate

    logic [4:0]             ex_dest_q, ex_dest_d;
    logic                   ex_rf_en_q, ex_rf_en_d;
    logic                   ex_load_q, ex_load_d;
    logic [4:0]             mem_dest_q;
    logic                   mem_rf_en_q;
    logic                   mem_load_q;
    logic [4:0]             wb_dest_q;
    logic                   wb_rf_en_q;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic ex_hit_rs, mem_hit_rs, wb_hit_rs;
    logic ex_hit_rt, mem_hit_rt, wb_hit_rt;
    logic stall;

    // Register 0 is hardwired, so it never matches regardless of stage state.
    function automatic logic stage_hit(input logic       uses,
                                       input logic [4:0] src,
                                       input logic       rf_en,
                                       input logic [4:0] dest);
        return uses && (src != 5'd0) && rf_en && (dest == src);
    endfunction

    // A load in EX has no data yet, so it falls through to the older stages.
    function automatic logic [1:0] pick_sel(input logic ex_hit,
                                            input logic ex_is_load,
                                            input logic mem_hit,
                                            input logic wb_hit);
        if (ex_hit && !ex_is_load) return 2'b01;
        if (mem_hit)               return 2'b10;
        if (wb_hit)                return 2'b11;
        return 2'b00;
    endfunction

    assign ex_hit_rs  = stage_hit(id_uses_rs, id_rs, ex_rf_en_q,  ex_dest_q);
    assign mem_hit_rs = stage_hit(id_uses_rs, id_rs, mem_rf_en_q, mem_dest_q);
    assign wb_hit_rs  = stage_hit(id_uses_rs, id_rs, wb_rf_en_q,  wb_dest_q);
    assign ex_hit_rt  = stage_hit(id_uses_rt, id_rt, ex_rf_en_q,  ex_dest_q);
    assign mem_hit_rt = stage_hit(id_uses_rt, id_rt, mem_rf_en_q, mem_dest_q);
    assign wb_hit_rt  = stage_hit(id_uses_rt, id_rt, wb_rf_en_q,  wb_dest_q);

    assign stall = ex_load_q && (ex_hit_rs || ex_hit_rt);

    always_comb begin
        fwd_sel_a         = pick_sel(ex_hit_rs, ex_load_q, mem_hit_rs, wb_hit_rs);
        fwd_sel_b         = pick_sel(ex_hit_rt, ex_load_q, mem_hit_rt, wb_hit_rt);
        control_mux       = stall;
        pc_load_enable    = !stall;
        if_id_load_enable = !stall;
        if (!rst_n) begin
            fwd_sel_a         = 2'b00;
            fwd_sel_b         = 2'b00;
            control_mux       = 1'b1;
            pc_load_enable    = 1'b0;
            if_id_load_enable = 1'b0;
        end
    end

    always_comb begin
        ex_dest_d   = id_dest_reg;
        ex_rf_en_d  = id_rf_enable;
        ex_load_d   = id_load_instr;
        stall_cnt_d = stall_cnt_q;
        if (stall) begin
            ex_dest_d  = 5'd0;
            ex_rf_en_d = 1'b0;
            ex_load_d  = 1'b0;
            if (!(&stall_cnt_q)) begin
                stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_dest_q   <= 5'd0;
            ex_rf_en_q  <= 1'b0;
            ex_load_q   <= 1'b0;
            mem_dest_q  <= 5'd0;
            mem_rf_en_q <= 1'b0;
            mem_load_q  <= 1'b0;
            wb_dest_q   <= 5'd0;
            wb_rf_en_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            ex_dest_q   <= ex_dest_d;
            ex_rf_en_q  <= ex_rf_en_d;
            ex_load_q   <= ex_load_d;
            mem_dest_q  <= ex_dest_q;
            mem_rf_en_q <= ex_rf_en_q;
            mem_load_q  <= ex_load_q;
            wb_dest_q   <= mem_dest_q;
            wb_rf_en_q  <= mem_rf_en_q;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // The MEM load flag is tracked for completeness; MEM data is always forwardable.
    logic unused_mem_load;
    assign unused_mem_load = mem_load_q;

    assign stall_count = stall_cnt_q;

endmodule
